calc_engine: RTL and testbench
==============================

CALC_ENGINE -- requirements
Module: calc_engine

Interface
REQ-001 The block SHALL take parameter DIGITS, default 2, giving the decimal digits per operand (legal 1..4).
REQ-002 The block SHALL derive localparam OPW = ceil(log2(10^DIGITS)), the binary operand width (7 for DIGITS=2).
REQ-003 The block SHALL derive localparam RW = 2*OPW, the binary result width, and RD = 2*DIGITS, the result digit count.
REQ-004 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Port rst  in  1  reset, asynchronous and active-high.
REQ-006 Port key_valid  in  1  one-cycle pulse qualifying key_code.
REQ-007 Port key_code  in  4  key: 0-9 digit, a +, b -, c *, d /, e =, f clear.
REQ-008 Port disp_bcd  out  4*RD  BCD display digits, digit 0 at LSBs; unused leading digits = 4'hF (blank).
REQ-009 Port disp_neg  out  1  result is negative.
REQ-010 Port disp_err  out  1  error indicator.
REQ-011 Port busy  out  1  high in CALC and CONV.
REQ-012 Port done  out  1  one-cycle pulse on entry to DONE.

Function
REQ-013 States SHALL be IDLE, A_ENT, OP, B_ENT, CALC, CONV, DONE and ERR.
REQ-014 Key f with key_valid SHALL force IDLE on the next edge from any state, including CALC and CONV, and SHALL clear all operands and outputs.
REQ-015 IDLE: a digit SHALL load operand A = digit and move to A_ENT; all other keys are ignored.
REQ-016 A_ENT/B_ENT: a digit SHALL update the operand to operand*10+digit while fewer than DIGITS digits are entered; further digits are ignored.
REQ-017 A_ENT: an op key (a-d) SHALL latch the operator and move to OP.
REQ-018 OP: a digit SHALL start B and move to B_ENT; a later op key replaces the latched operator.
REQ-019 B_ENT: key e SHALL move to CALC; op keys are ignored.
REQ-020 The block SHALL ignore every key except f while busy=1.
REQ-021 The + and - operations SHALL take 1 cycle in CALC.
REQ-022 The * operation SHALL be a shift-add multiply taking exactly OPW cycles in CALC.
REQ-023 The / operation SHALL be a restoring divide taking exactly OPW cycles, with the quotient truncated and the remainder discarded.
REQ-024 Subtraction with B > A SHALL produce magnitude B-A with disp_neg=1.
REQ-025 / with B=0 SHALL go from B_ENT directly to ERR without entering CALC.
REQ-026 CONV SHALL perform a sequential double-dabble of the RW-bit magnitude in exactly RW cycles.
REQ-027 CONV SHALL blank leading zeros, keeping at least one digit.
REQ-028 At the end of CONV the block SHALL enter DONE, assert done for 1 cycle, and hold disp_bcd.
REQ-029 DONE: a digit SHALL start a new A_ENT with that digit, clearing disp_neg; other keys are ignored.
REQ-030 In IDLE, A_ENT, OP and B_ENT, disp_bcd SHALL show the operand being entered, right-aligned, with the rest blank; OP shows A.
REQ-031 ERR SHALL set disp_err=1 and disp_bcd to "E" (4'hE) in digit 0, and only f exits it.
REQ-032 The end-to-end latency SHALL be from the = key edge to done: 1 cycle (B_ENT->CALC) + CALC cycles + RW cycles.

Reset
REQ-033 On rst the state SHALL be IDLE, disp_bcd all 4'hF, disp_neg=0, disp_err=0, busy=0, done=0, and operands and operator cleared.
REQ-034 When rst deasserts mid-CALC or mid-CONV, no result SHALL appear and done SHALL stay 0.

Configuration
REQ-035 With macro CALC_DIV_EN defined, / SHALL behave per REQ-023 and REQ-025.
REQ-036 Without CALC_DIV_EN, the divider SHALL be absent, and key d in A_ENT or OP SHALL go to ERR.

Verification (DIGITS=2, OPW=7, RW=14)
REQ-037 Keys 1,2,+,3,4,= -> done 16 cycles after =; disp_bcd shows 46 with digits 2-3 blank; disp_neg=0.
REQ-038 Keys 5,-,2,7,= -> disp_bcd shows 22; disp_neg=1.
REQ-039 Keys 9,9,*,9,9,= -> done 22 cycles after =; disp_bcd shows 9801.
REQ-040 Keys 7,/,0,= -> ERR with disp_err=1; then f -> IDLE, all blank.
REQ-041 Keys 1,2,3,/,4,= -> operand A = 12 (3 ignored); result 3.
REQ-042 Keys 8,*,8,=, then f on the 3rd busy cycle -> IDLE next cycle, done never pulses; a digit keyed during busy is ignored.

Source files
------------

// File: rtl/calc_engine_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : calc_engine_if
// Purpose  : Keypad / display bundle between a key source and calc_engine.
// Ports    : key_valid  - one-cycle strobe qualifying key_code
//            key_code   - 0-9 digit, a +, b -, c *, d /, e =, f clear
//            disp_bcd   - 4*RD bits of BCD display, digit 0 at the LSBs
//            disp_neg   - displayed result is negative
//            disp_err   - error indicator
//            busy       - engine is computing or converting
//            done       - one-cycle pulse when a result is displayed
// Modports : master (key source), slave (calc_engine)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface calc_engine_if #(
   parameter int DIGITS = 2
);
   localparam int RD = 2 * DIGITS;

   logic              key_valid;
   logic [3:0]        key_code;
   logic [4*RD-1:0]   disp_bcd;
   logic              disp_neg;
   logic              disp_err;
   logic              busy;
   logic              done;

   modport master (
      output key_valid, key_code,
      input  disp_bcd, disp_neg, disp_err, busy, done
   );

   modport slave (
      input  key_valid, key_code,
      output disp_bcd, disp_neg, disp_err, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/calc_engine.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : calc_engine
// Purpose  : Keypad-driven decimal calculator. Two DIGITS-digit operands are
//            keyed in, combined with + - * (and / when enabled), and the
//            result is converted to BCD with a sequential double-dabble.
// Ports    : clk    - clock, rising edge
//            rst    - asynchronous active-high reset
//            io_bus - calc_engine_if.slave (key inputs, display outputs)
// Config   : CALC_DIV_EN - when defined, the restoring divider is built;
//            otherwise key d in A_ENT or OP leads to the error state.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module calc_engine #(
   parameter int DIGITS = 2
) (
   input  logic          clk,
   input  logic          rst,
   calc_engine_if.slave  io_bus
);
   localparam int OPW = $clog2(10 ** DIGITS);
   localparam int RW  = 2 * OPW;
   localparam int RD  = 2 * DIGITS;
   localparam int CW  = $clog2(RW + 1);

   // Operator code is key_code[1:0] ^ 2'b10: a->0, b->1, c->2, d->3
   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_DIV = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE, S_A_ENT, S_OP, S_B_ENT, S_CALC, S_CONV, S_DONE, S_ERR
   } state_t;

   state_t              r_state;
   logic [OPW-1:0]      r_a, r_b;
   logic [2:0]          r_na, r_nb;
   logic [1:0]          r_op;
   logic [4*DIGITS-1:0] r_ent;
   logic [CW-1:0]       r_cnt;
   logic [RW-1:0]       r_acc, r_mc, r_bin;
   logic [OPW-1:0]      r_mq;
   logic [4*RD-1:0]     r_bcd, r_disp;
   logic                r_sign, r_neg, r_err, r_busy, r_done;

   logic                w_key_dig, w_key_op, w_key_eq, w_key_clr, w_key_div;
   logic [4*DIGITS-1:0] w_ent_shift, w_ent_first;
   logic [RW-1:0]       w_sum, w_mul_acc, w_calc_res;
   logic                w_a_lt_b, w_calc_last, w_calc_sign;
   logic [4*RD-1:0]     w_bcd_adj, w_bcd_shift;

   assign w_key_dig   = io_bus.key_valid && (io_bus.key_code <= 4'd9);
   assign w_key_op    = io_bus.key_valid && (io_bus.key_code >= 4'hA) && (io_bus.key_code <= 4'hD);
   assign w_key_eq    = io_bus.key_valid && (io_bus.key_code == 4'hE);
   assign w_key_clr   = io_bus.key_valid && (io_bus.key_code == 4'hF);
   assign w_key_div   = io_bus.key_code == 4'hD;

   assign w_ent_shift = (r_ent << 4) | (4*DIGITS)'(io_bus.key_code);
   assign w_ent_first = (4*DIGITS)'(io_bus.key_code);

   assign w_sum       = RW'(r_a) + RW'(r_b);
   assign w_a_lt_b    = r_a < r_b;
   assign w_mul_acc   = r_mq[0] ? (r_acc + r_mc) : r_acc;

   // Operand accumulate; callers only use it while fewer than DIGITS digits
   // are entered, so the result always fits in OPW bits.
   function automatic logic [OPW-1:0] f_mac10(input logic [OPW-1:0] v, input logic [3:0] d);
      return (v * OPW'(10)) + OPW'(d);
   endfunction

   // Replace leading zero digits with blank, always keeping digit 0.
   function automatic logic [4*RD-1:0] f_blank(input logic [4*RD-1:0] v);
      logic [4*RD-1:0] r;
      logic            lead;
      r    = v;
      lead = 1'b1;
      for (int i = RD - 1; i > 0; i--) begin
         if (lead && (v[4*i +: 4] == 4'd0)) r[4*i +: 4] = 4'hF;
         else                               lead = 1'b0;
      end
      return r;
   endfunction

   function automatic logic [4*RD-1:0] f_show_ent(input logic [4*DIGITS-1:0] e);
      return f_blank((4*RD)'(e));
   endfunction

`ifdef CALC_DIV_EN
   logic [OPW:0]   r_rem;
   logic [OPW-1:0] r_quo;
   logic [OPW:0]   w_rem_sh, w_trial, w_rem_nx;
   logic [OPW-1:0] w_quo_nx;

   // Restoring step: trial-subtract the divisor, keep it when non-negative.
   assign w_rem_sh = {r_rem[OPW-1:0], r_quo[OPW-1]};
   assign w_trial  = w_rem_sh - {1'b0, r_b};
   assign w_rem_nx = w_trial[OPW] ? w_rem_sh : w_trial;
   assign w_quo_nx = {r_quo[OPW-2:0], ~w_trial[OPW]};
`endif

   always_comb begin
      w_calc_last = 1'b1;
      w_calc_res  = w_sum;
      w_calc_sign = 1'b0;
      case (r_op)
         OP_SUB: begin
            w_calc_res  = w_a_lt_b ? RW'(r_b - r_a) : RW'(r_a - r_b);
            w_calc_sign = w_a_lt_b;
         end
         OP_MUL: begin
            w_calc_last = r_cnt == CW'(OPW - 1);
            w_calc_res  = w_mul_acc;
         end
`ifdef CALC_DIV_EN
         OP_DIV: begin
            w_calc_last = r_cnt == CW'(OPW - 1);
            w_calc_res  = RW'(w_quo_nx);
         end
`endif
         default: ;
      endcase
   end

   // Double-dabble: add 3 to every digit >= 5, then shift in the next bit.
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < RD; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
   end
   assign w_bcd_shift = {w_bcd_adj[4*RD-2:0], r_bin[RW-1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst || w_key_clr) begin
         // Clear key and reset share the same return-to-idle behaviour.
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_na    <= '0;
         r_nb    <= '0;
         r_op    <= '0;
         r_ent   <= '0;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_mc    <= '0;
         r_mq    <= '0;
         r_bin   <= '0;
         r_bcd   <= '0;
         r_disp  <= '1;
         r_sign  <= 1'b0;
         r_neg   <= 1'b0;
         r_err   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef CALC_DIV_EN
         r_rem   <= '0;
         r_quo   <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_key_dig) begin
                  r_a     <= OPW'(io_bus.key_code);
                  r_na    <= 3'd1;
                  r_ent   <= w_ent_first;
                  r_disp  <= f_show_ent(w_ent_first);
                  r_neg   <= 1'b0;
                  r_state <= S_A_ENT;
               end
            end
            S_A_ENT, S_OP: begin
               if (w_key_dig && r_state == S_A_ENT) begin
                  if (r_na < 3'(DIGITS)) begin
                     r_a    <= f_mac10(r_a, io_bus.key_code);
                     r_na   <= r_na + 3'd1;
                     r_ent  <= w_ent_shift;
                     r_disp <= f_show_ent(w_ent_shift);
                  end
               end else if (w_key_dig) begin
                  r_b     <= OPW'(io_bus.key_code);
                  r_nb    <= 3'd1;
                  r_ent   <= w_ent_first;
                  r_disp  <= f_show_ent(w_ent_first);
                  r_state <= S_B_ENT;
               end else if (w_key_op) begin
`ifndef CALC_DIV_EN
                  if (w_key_div) begin
                     r_err   <= 1'b1;
                     r_disp  <= {{(4*RD-4){1'b1}}, 4'hE};
                     r_state <= S_ERR;
                  end else
`endif
                  begin
                     r_op    <= io_bus.key_code[1:0] ^ 2'b10;
                     r_state <= S_OP;
                  end
               end
            end
            S_B_ENT: begin
               if (w_key_dig) begin
                  if (r_nb < 3'(DIGITS)) begin
                     r_b    <= f_mac10(r_b, io_bus.key_code);
                     r_nb   <= r_nb + 3'd1;
                     r_ent  <= w_ent_shift;
                     r_disp <= f_show_ent(w_ent_shift);
                  end
               end else if (w_key_eq) begin
                  if (r_op == OP_DIV && r_b == '0) begin
                     r_err   <= 1'b1;
                     r_disp  <= {{(4*RD-4){1'b1}}, 4'hE};
                     r_state <= S_ERR;
                  end else begin
                     r_cnt   <= '0;
                     r_acc   <= '0;
                     r_mc    <= RW'(r_a);
                     r_mq    <= r_b;
                     r_busy  <= 1'b1;
                     r_state <= S_CALC;
`ifdef CALC_DIV_EN
                     r_rem   <= '0;
                     r_quo   <= r_a;
`endif
                  end
               end
            end
            S_CALC: begin
               r_acc <= w_mul_acc;
               r_mq  <= r_mq >> 1;
               r_mc  <= r_mc << 1;
               r_cnt <= r_cnt + CW'(1);
`ifdef CALC_DIV_EN
               r_rem <= w_rem_nx;
               r_quo <= w_quo_nx;
`endif
               if (w_calc_last) begin
                  r_bin   <= w_calc_res;
                  r_sign  <= w_calc_sign;
                  r_cnt   <= '0;
                  r_bcd   <= '0;
                  r_state <= S_CONV;
               end
            end
            S_CONV: begin
               // RW shift cycles, then one cycle to publish the blanked result.
               if (r_cnt == CW'(RW)) begin
                  r_disp  <= f_blank(r_bcd);
                  r_neg   <= r_sign;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_bcd <= w_bcd_shift;
                  r_bin <= r_bin << 1;
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: ; // S_ERR: only the clear key leaves
         endcase
      end
   end

   assign io_bus.disp_bcd = r_disp;
   assign io_bus.disp_neg = r_neg;
   assign io_bus.disp_err = r_err;
   assign io_bus.busy     = r_busy;
   assign io_bus.done     = r_done;
endmodule
`default_nettype wire

// File: tb/tb_calc_engine.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_calc_engine
// Purpose  : Self-checking bench for calc_engine (DIGITS=2). A behavioural
//            model of the keypad calculator predicts every output each cycle;
//            directed sequences pin known results, then random keys run.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_calc_engine;
   localparam int DIGITS = 2;
   localparam int OPW    = $clog2(10 ** DIGITS);
   localparam int RW     = 2 * OPW;
   localparam int RD     = 2 * DIGITS;
`ifdef CALC_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   localparam int M_IDLE = 0, M_A = 1, M_OP = 2, M_B = 3, M_BUSY = 4, M_DONE = 5, M_ERR = 6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   calc_engine_if #(.DIGITS(DIGITS)) bus ();
   calc_engine #(.DIGITS(DIGITS)) dut (.clk(clk), .rst(rst), .io_bus(bus.slave));

   int checks = 0;
   int errors = 0;
   int m_mode, m_a, m_b, m_na, m_nb, m_op, m_cd, m_res;
   bit m_rneg;
   logic [4*RD-1:0] e_disp;
   bit e_neg, e_err, e_busy, e_done;
   bit saw_done;
   int lat;

   function automatic logic [4*RD-1:0] fmt(input int v);
      logic [4*RD-1:0] r;
      for (int i = 0; i < RD; i++) begin
         if (i == 0 || v >= 10 ** i) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
         else                        r[4*i +: 4] = 4'hF;
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         if (errors <= 30)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
      end
   endtask

   task automatic compare();
      chk("disp_bcd", 64'(bus.disp_bcd), 64'(e_disp));
      chk("disp_neg", 64'(bus.disp_neg), 64'(e_neg));
      chk("disp_err", 64'(bus.disp_err), 64'(e_err));
      chk("busy",     64'(bus.busy),     64'(e_busy));
      chk("done",     64'(bus.done),     64'(e_done));
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_op = 0; m_cd = 0;
      m_res = 0; m_rneg = 0;
      e_disp = '1; e_neg = 0; e_err = 0; e_busy = 0; e_done = 0;
   endtask

   task automatic go_err();
      m_mode = M_ERR; e_err = 1; e_neg = 0;
      e_disp = '1;
      e_disp[3:0] = 4'hE;
   endtask

   task automatic start_a(input int d);
      m_a = d; m_na = 1; m_mode = M_A; e_neg = 0; e_disp = fmt(m_a);
   endtask

   task automatic latch_op(input int k);
      if (k == 13 && !DIV_EN) go_err();
      else begin m_op = k; m_mode = M_OP; end
   endtask

   // Predicts the outputs after the next rising edge given this cycle's key.
   task automatic model_step(input bit kv, input logic [3:0] kc);
      bit dig, opk;
      int k;
      k   = int'(kc);
      dig = kv && k <= 9;
      opk = kv && k >= 10 && k <= 13;
      e_done = 0;
      if (kv && k == 15) begin
         model_reset();
         return;
      end
      case (m_mode)
         M_IDLE, M_DONE: if (dig) start_a(k);
         M_A: begin
            if (dig) begin
               if (m_na < DIGITS) begin m_a = m_a * 10 + k; m_na++; e_disp = fmt(m_a); end
            end else if (opk) latch_op(k);
         end
         M_OP: begin
            if (dig) begin m_b = k; m_nb = 1; m_mode = M_B; e_disp = fmt(m_b); end
            else if (opk) latch_op(k);
         end
         M_B: begin
            if (dig) begin
               if (m_nb < DIGITS) begin m_b = m_b * 10 + k; m_nb++; e_disp = fmt(m_b); end
            end else if (kv && k == 14) begin
               if (m_op == 13 && m_b == 0) go_err();
               else begin
                  m_rneg = 0;
                  case (m_op)
                     10: m_res = m_a + m_b;
                     11: begin
                        m_rneg = m_b > m_a;
                        m_res  = m_rneg ? m_b - m_a : m_a - m_b;
                     end
                     12: m_res = m_a * m_b;
                     default: m_res = m_a / m_b;
                  endcase
                  m_cd   = 1 + ((m_op >= 12) ? OPW : 1) + RW;
                  m_mode = M_BUSY;
                  e_busy = 1;
               end
            end
         end
         M_BUSY: begin
            m_cd--;
            if (m_cd == 0) begin
               m_mode = M_DONE; e_busy = 0; e_done = 1;
               e_disp = fmt(m_res); e_neg = m_rneg;
            end
         end
         default: ;
      endcase
   endtask

   task automatic cyc(input bit kv, input logic [3:0] kc);
      bus.key_valid = kv;
      bus.key_code  = kc;
      model_step(kv, kc);
      @(negedge clk);
      compare();
      if (bus.done === 1'b1) saw_done = 1;
   endtask

   task automatic press(input logic [3:0] kc);
      cyc(1'b1, kc);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         cyc(1'b0, 4'h0);
         n++;
      end while (bus.done !== 1'b1 && n < 200);
   endtask

   task automatic do_reset();
      bus.key_valid = 1'b0;
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      compare();
      rst = 1'b0;
   endtask

   initial begin
      bus.key_valid = 1'b0;
      bus.key_code  = 4'h0;
      rst = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      compare();
      chk("reset_disp_lit", 64'(bus.disp_bcd), 64'hFFFF);
      rst = 1'b0;

      // 12 + 34 = 46
      press(4'h1); press(4'h2);
      chk("entry_12_lit", 64'(bus.disp_bcd), 64'hFF12);
      press(4'hA); press(4'h3); press(4'h4); press(4'hE);
      wait_done(lat);
      chk("lat_add_lit", 64'(lat), 64'd16);
      chk("res_46_lit", 64'(bus.disp_bcd), 64'hFF46);
      chk("neg_46_lit", 64'(bus.disp_neg), 64'd0);

      // 5 - 27 = -22, then a digit clears the sign
      press(4'hF);
      press(4'h5); press(4'hB); press(4'h2); press(4'h7); press(4'hE);
      wait_done(lat);
      chk("res_22_lit", 64'(bus.disp_bcd), 64'hFF22);
      chk("neg_22_lit", 64'(bus.disp_neg), 64'd1);
      press(4'h6);
      chk("newa_neg_lit", 64'(bus.disp_neg), 64'd0);
      chk("newa_disp_lit", 64'(bus.disp_bcd), 64'hFFF6);

      // 99 * 99 = 9801
      press(4'hF);
      press(4'h9); press(4'h9); press(4'hC); press(4'h9); press(4'h9); press(4'hE);
      wait_done(lat);
      chk("lat_mul_lit", 64'(lat), 64'd22);
      chk("res_9801_lit", 64'(bus.disp_bcd), 64'h9801);

      // 7 / 0 -> error (also error via key d when the divider is absent)
      press(4'hF);
      press(4'h7); press(4'hD); press(4'h0); press(4'hE); cyc(1'b0, 4'h0);
      chk("err_flag_lit", 64'(bus.disp_err), 64'd1);
      chk("err_disp_lit", 64'(bus.disp_bcd), 64'hFFFE);
      press(4'hF);
      chk("err_clr_disp_lit", 64'(bus.disp_bcd), 64'hFFFF);
      chk("err_clr_flag_lit", 64'(bus.disp_err), 64'd0);

`ifdef CALC_DIV_EN
      press(4'h1); press(4'h2); press(4'h3);
      chk("a_12_lit", 64'(bus.disp_bcd), 64'hFF12);
      press(4'hD); press(4'h4); press(4'hE);
      wait_done(lat);
      chk("lat_div_lit", 64'(lat), 64'd22);
      chk("res_3_lit", 64'(bus.disp_bcd), 64'hFFF3);
      press(4'hF);
`endif

      // clear on the third busy cycle; a digit during busy is ignored
      press(4'h8); press(4'hC); press(4'h8); press(4'hE);
      press(4'h5);
      cyc(1'b0, 4'h0);
      saw_done = 0;
      press(4'hF);
      chk("abort_busy_lit", 64'(bus.busy), 64'd0);
      chk("abort_disp_lit", 64'(bus.disp_bcd), 64'hFFFF);
      repeat (40) cyc(1'b0, 4'h0);
      chk("abort_no_done", 64'(saw_done), 64'd0);
      press(4'h3);
      chk("abort_idle_lit", 64'(bus.disp_bcd), 64'hFFF3);

      // reset in the middle of a computation
      press(4'hF);
      press(4'h1); press(4'hA); press(4'h1); press(4'hE);
      repeat (4) cyc(1'b0, 4'h0);
      do_reset();
      saw_done = 0;
      repeat (30) cyc(1'b0, 4'h0);
      chk("rst_no_done", 64'(saw_done), 64'd0);

      // random keys against the model
      for (int n = 0; n < 4000; n++) begin
         int r;
         logic [3:0] kc;
         if ($urandom_range(0, 599) == 0) begin
            do_reset();
         end else begin
            r = int'($urandom_range(0, 99));
            if (r < 60)      kc = 4'($urandom_range(0, 9));
            else if (r < 80) kc = 4'($urandom_range(10, 13));
            else if (r < 98) kc = 4'hE;
            else             kc = 4'hF;
            cyc($urandom_range(0, 9) < 6, kc);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
